// File: rtl/pid_controller_param_pkg.sv
// Shared types for the parametrised PID controller: FSM state encoding and gain register selects.
package pid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        TERMS,
        SUM,
        OUT
    } pid_state_e;

    localparam logic [1:0] SEL_KP  = 2'd0;
    localparam logic [1:0] SEL_KI  = 2'd1;
    localparam logic [1:0] SEL_KD  = 2'd2;
    localparam logic [1:0] SEL_CLR = 2'd3;

endpackage

// File: rtl/pid_controller_param_if.sv
// Sample/gain/result bus of the PID controller; master drives samples and gain writes.
interface pid_controller_param_if #(
    parameter int DATA_W = 8,
    parameter int GAIN_W = 8
);
    logic              sample_valid;
    logic [DATA_W-1:0] setpoint;
    logic [DATA_W-1:0] feedback;
    logic              gain_we;
    logic [1:0]        gain_sel;
    logic [GAIN_W-1:0] gain_data;
    logic              busy;
    logic              out_valid;
    logic [DATA_W-1:0] control_out;

    modport master (
        output sample_valid, setpoint, feedback, gain_we, gain_sel, gain_data,
        input  busy, out_valid, control_out
    );

    modport slave (
        input  sample_valid, setpoint, feedback, gain_we, gain_sel, gain_data,
        output busy, out_valid, control_out
    );
endinterface

// File: rtl/pid_controller_param_sat.sv
// Signed clamp of an IN_W-bit value into [LO, HI], truncated to OUT_W bits after clamping.
module pid_sat #(
    parameter int             IN_W  = 17,
    parameter int             OUT_W = 16,
    parameter longint signed  LO    = -4095,
    parameter longint signed  HI    = 4095
) (
    input  logic signed [IN_W-1:0] din,
    output logic        [OUT_W-1:0] dout
);
    localparam logic signed [IN_W-1:0] LO_V = IN_W'(LO);
    localparam logic signed [IN_W-1:0] HI_V = IN_W'(HI);

    logic signed [IN_W-1:0] clamped;

    always_comb begin
        clamped = din;
        if (din < LO_V)      clamped = LO_V;
        else if (din > HI_V) clamped = HI_V;
        dout = OUT_W'(clamped);
    end
endmodule

// File: rtl/pid_controller_param.sv
// Runtime-programmable PID controller with anti-windup integrator and saturated unsigned output.
// Optional derivative IIR filter enabled by defining PID_DERIV_FILTER_EN.
module pid_controller_param
    import pid_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int GAIN_W    = 8,
    parameter int FRAC_BITS = 4,
    parameter int ACC_W     = 16,
    parameter int INT_LIMIT = 4095,
    parameter int KP_RST    = 32,
    parameter int KI_RST    = 0,
    parameter int KD_RST    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pid_controller_param_if.slave    bus
);
    localparam int E_W = DATA_W + 1;
    localparam int D_W = DATA_W + 2;
    localparam int P_W = ACC_W + GAIN_W + 2;

    pid_state_e              state;
    logic [GAIN_W-1:0]       kp, ki, kd;
    logic [GAIN_W-1:0]       kp_s, ki_s, kd_s;
    logic [DATA_W-1:0]       sp_q, fb_q;
    logic signed [E_W-1:0]   err, prev_err;
    logic signed [ACC_W-1:0] integral;
    logic                    first;
    logic signed [D_W-1:0]   deriv_raw, d_use;
    logic signed [ACC_W:0]   int_sum;
    logic [ACC_W-1:0]        int_clamped;
    logic signed [P_W-1:0]   acc_full, acc_sh;
    logic [DATA_W-1:0]       out_clamped;
    logic                    clr;

    assign clr       = bus.gain_we && (bus.gain_sel == SEL_CLR);
    assign int_sum   = (ACC_W+1)'(integral) + (ACC_W+1)'(err);
    assign deriv_raw = first ? '0 : (D_W'(err) - D_W'(prev_err));

`ifdef PID_DERIV_FILTER_EN
    logic signed [D_W-1:0] dfilt, dfilt_next;
    logic signed [D_W:0]   dfilt_diff;
    assign dfilt_diff = (D_W+1)'(deriv_raw) - (D_W+1)'(dfilt);
    assign dfilt_next = dfilt + D_W'(dfilt_diff >>> 2);
    assign d_use      = dfilt;
`else
    logic signed [D_W-1:0] deriv;
    assign d_use = deriv;
`endif

    // Gains are zero-extended into signed operands so unsigned gains never flip the product sign.
    assign acc_full = P_W'($signed({1'b0, kp_s})) * P_W'(err)
                    + P_W'($signed({1'b0, ki_s})) * P_W'(integral)
                    + P_W'($signed({1'b0, kd_s})) * P_W'(d_use);
    assign acc_sh   = acc_full >>> FRAC_BITS;

    pid_sat #(.IN_W(ACC_W+1), .OUT_W(ACC_W), .LO(-INT_LIMIT), .HI(INT_LIMIT))
        u_int_sat (.din(int_sum), .dout(int_clamped));

    pid_sat #(.IN_W(P_W), .OUT_W(DATA_W), .LO(0), .HI((2**DATA_W)-1))
        u_out_sat (.din(acc_sh), .dout(out_clamped));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kp <= GAIN_W'(KP_RST);
            ki <= GAIN_W'(KI_RST);
            kd <= GAIN_W'(KD_RST);
        end else if (bus.gain_we) begin
            case (bus.gain_sel)
                SEL_KP:  kp <= bus.gain_data;
                SEL_KI:  ki <= bus.gain_data;
                SEL_KD:  kd <= bus.gain_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.busy        <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.control_out <= '0;
            sp_q            <= '0;
            fb_q            <= '0;
            kp_s            <= '0;
            ki_s            <= '0;
            kd_s            <= '0;
            err             <= '0;
            prev_err        <= '0;
            integral        <= '0;
            first           <= 1'b1;
`ifdef PID_DERIV_FILTER_EN
            dfilt           <= '0;
`else
            deriv           <= '0;
`endif
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                IDLE: if (bus.sample_valid) begin
                    sp_q     <= bus.setpoint;
                    fb_q     <= bus.feedback;
                    kp_s     <= kp;
                    ki_s     <= ki;
                    kd_s     <= kd;
                    bus.busy <= 1'b1;
                    state    <= ERR;
                end
                ERR: begin
                    err   <= $signed({1'b0, sp_q}) - $signed({1'b0, fb_q});
                    state <= TERMS;
                end
                TERMS: begin
                    integral <= $signed(int_clamped);
`ifdef PID_DERIV_FILTER_EN
                    dfilt    <= dfilt_next;
`else
                    deriv    <= deriv_raw;
`endif
                    prev_err <= err;
                    first    <= 1'b0;
                    state    <= SUM;
                end
                // Output registers load on the edge into OUT so out_valid is high throughout OUT.
                SUM: begin
                    bus.control_out <= out_clamped;
                    bus.out_valid   <= 1'b1;
                    state           <= OUT;
                end
                OUT: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A clear overrides any history update made in TERMS on the same edge.
            if (clr) begin
                integral <= '0;
                prev_err <= '0;
                first    <= 1'b1;
`ifdef PID_DERIV_FILTER_EN
                dfilt    <= '0;
`else
                if (state == TERMS) deriv <= '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_pid_controller_param.sv
// Directed self-checking bench for pid_controller_param (default build, plus an INT_LIMIT=25 instance).
module tb_pid_controller_param;
    import pid_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pid_controller_param_if #(.DATA_W(8), .GAIN_W(8)) bus0 ();
    pid_controller_param_if #(.DATA_W(8), .GAIN_W(8)) bus1 ();

    pid_controller_param dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    pid_controller_param #(.INT_LIMIT(25), .KP_RST(0), .KI_RST(16), .KD_RST(0))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_chk = 0;
    int n_fail = 0;

    function automatic logic ov(input bit u);
        return u ? bus1.out_valid : bus0.out_valid;
    endfunction

    task automatic wr_gain(input logic [1:0] sel, input logic [7:0] d);
        @(negedge clk);
        bus0.gain_we = 1'b1; bus0.gain_sel = sel; bus0.gain_data = d;
        @(negedge clk);
        bus0.gain_we = 1'b0;
    endtask

    // Accept one sample, then wait (bounded) for out_valid; lat counts cycles after accept.
    task automatic run(input bit u, input logic [7:0] sp, input logic [7:0] fb,
                       output logic [7:0] res, output int lat);
        @(negedge clk);
        if (u) begin bus1.sample_valid = 1'b1; bus1.setpoint = sp; bus1.feedback = fb; end
        else   begin bus0.sample_valid = 1'b1; bus0.setpoint = sp; bus0.feedback = fb; end
        @(negedge clk);
        bus0.sample_valid = 1'b0; bus1.sample_valid = 1'b0;
        lat = 1;
        while (!ov(u) && lat < 20) begin @(negedge clk); lat++; end
        res = u ? bus1.control_out : bus0.control_out;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus0.busy); end
        n_chk++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus0.out_valid); end
        n_chk++; if (bus0.control_out !== 8'd0) begin n_fail++; $display("FAIL reset_control_out got %0d exp 0", bus0.control_out); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_proportional;
        logic [7:0] r; int l;
        run(0, 8'd100, 8'd60, r, l);
        n_chk++; if (l !== 4) begin n_fail++; $display("FAIL prop_latency got %0d exp 4", l); end
        n_chk++; if (r !== 8'd80) begin n_fail++; $display("FAIL prop_value got %0d exp 80", r); end
    endtask

    task automatic test_saturation;
        logic [7:0] r; int l;
        run(0, 8'd255, 8'd0, r, l);
        n_chk++; if (r !== 8'd255) begin n_fail++; $display("FAIL sat_high got %0d exp 255", r); end
        run(0, 8'd0, 8'd50, r, l);
        n_chk++; if (r !== 8'd0) begin n_fail++; $display("FAIL sat_low got %0d exp 0", r); end
    endtask

    task automatic test_integral;
        logic [7:0] r; int l;
        logic [7:0] exp_lim [4] = '{8'd10, 8'd20, 8'd25, 8'd25};
        wr_gain(SEL_KP, 8'd0);
        wr_gain(SEL_KI, 8'd16);
        wr_gain(SEL_CLR, 8'd0);
        for (int i = 0; i < 3; i++) begin
            run(0, 8'd70, 8'd60, r, l);
            n_chk++; if (r !== 8'(10*(i+1))) begin n_fail++; $display("FAIL integ_%0d got %0d exp %0d", i, r, 10*(i+1)); end
        end
        for (int i = 0; i < 4; i++) begin
            run(1, 8'd70, 8'd60, r, l);
            n_chk++; if (r !== exp_lim[i]) begin n_fail++; $display("FAIL windup_%0d got %0d exp %0d", i, r, exp_lim[i]); end
        end
    endtask

    task automatic test_derivative;
        logic [7:0] r; int l;
        wr_gain(SEL_KI, 8'd0);
        wr_gain(SEL_KD, 8'd16);
        wr_gain(SEL_CLR, 8'd0);
        run(0, 8'd80, 8'd60, r, l);
        n_chk++; if (r !== 8'd0) begin n_fail++; $display("FAIL deriv_first got %0d exp 0", r); end
        run(0, 8'd90, 8'd60, r, l);
        n_chk++; if (r !== 8'd10) begin n_fail++; $display("FAIL deriv_step got %0d exp 10", r); end
        wr_gain(SEL_CLR, 8'd0);
        run(0, 8'd90, 8'd60, r, l);
        n_chk++; if (r !== 8'd0) begin n_fail++; $display("FAIL deriv_clear got %0d exp 0", r); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] r; int l; int cnt;
        wr_gain(SEL_KD, 8'd0);
        wr_gain(SEL_KP, 8'd32);
        // Second sample_valid pulse lands in TERMS and must be dropped.
        @(negedge clk);
        bus0.sample_valid = 1'b1; bus0.setpoint = 8'd100; bus0.feedback = 8'd60;
        cnt = 0; r = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus0.out_valid) begin cnt++; r = bus0.control_out; end
            if (c == 2) begin
                n_chk++; if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL busy_inflight got %b exp 1", bus0.busy); end
            end
            if (c == 5) begin
                n_chk++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL busy_done got %b exp 0", bus0.busy); end
            end
            bus0.sample_valid = (c == 2);
        end
        n_chk++; if (cnt !== 1) begin n_fail++; $display("FAIL ignore_count got %0d exp 1", cnt); end
        n_chk++; if (r !== 8'd80) begin n_fail++; $display("FAIL ignore_value got %0d exp 80", r); end

        // kp write while in SUM: current result keeps the snapshot.
        @(negedge clk);
        bus0.sample_valid = 1'b1; bus0.setpoint = 8'd100; bus0.feedback = 8'd60;
        cnt = 0; r = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus0.sample_valid = 1'b0;
            if (bus0.out_valid) begin cnt++; r = bus0.control_out; end
            bus0.gain_we = (c == 3); bus0.gain_sel = SEL_KP; bus0.gain_data = 8'd64;
        end
        n_chk++; if (r !== 8'd80 || cnt !== 1) begin n_fail++; $display("FAIL snapshot_value got %0d/%0d exp 80/1", r, cnt); end
        run(0, 8'd100, 8'd60, r, l);
        n_chk++; if (r !== 8'd160) begin n_fail++; $display("FAIL new_kp_value got %0d exp 160", r); end
    endtask

    task automatic test_reset_midop;
        logic [7:0] r; int l; int cnt;
        @(negedge clk);
        bus0.sample_valid = 1'b1; bus0.setpoint = 8'd100; bus0.feedback = 8'd60;
        @(negedge clk); bus0.sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", bus0.busy); end
        n_chk++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b exp 0", bus0.out_valid); end
        n_chk++; if (bus0.control_out !== 8'd0) begin n_fail++; $display("FAIL midrst_control_out got %0d exp 0", bus0.control_out); end
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus0.out_valid) cnt++;
        end
        n_chk++; if (cnt !== 0) begin n_fail++; $display("FAIL midrst_no_output got %0d exp 0", cnt); end
        run(0, 8'd100, 8'd60, r, l);
        n_chk++; if (r !== 8'd80) begin n_fail++; $display("FAIL midrst_kp_reset got %0d exp 80", r); end
    endtask

    initial begin
        bus0.sample_valid = 1'b0; bus0.setpoint = '0; bus0.feedback = '0;
        bus0.gain_we = 1'b0; bus0.gain_sel = '0; bus0.gain_data = '0;
        bus1.sample_valid = 1'b0; bus1.setpoint = '0; bus1.feedback = '0;
        bus1.gain_we = 1'b0; bus1.gain_sel = '0; bus1.gain_data = '0;
        test_reset();
        test_proportional();
        test_saturation();
        test_integral();
        test_derivative();
        test_back_to_back();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
